// File: rtl/pipe_md_sched_if.sv
// Decode-side bundle between the D stage and the multiply/divide scheduler.
// Optional macro PIPE_MD_ABORT_EN adds the md_abort squash input.
interface pipe_md_sched_if;
  // D-stage instruction attributes and forwarded operands
  logic        d_valid;
  logic        d_md;
  logic        d_div;
  logic        d_sign;
  logic        d_hilo_rd;
  logic        d_hilo_wr;
  logic        ext_stall;
  logic [31:0] da;
  logic [31:0] db;
`ifdef PIPE_MD_ABORT_EN
  logic        md_abort;
`endif
  // Scheduler outputs towards the unit, HI/LO and the PC/IR enables
  logic        md_start;
  logic        md_div;
  logic        md_sign;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic        md_dz;
  logic        hilo_we;
  logic        md_stall;

  // Decode side drives instruction info, observes the scheduler
  modport master (
    output d_valid, d_md, d_div, d_sign, d_hilo_rd, d_hilo_wr, ext_stall, da, db,
`ifdef PIPE_MD_ABORT_EN
    output md_abort,
`endif
    input  md_start, md_div, md_sign, md_a, md_b, md_busy, md_dz, hilo_we, md_stall
  );

  // Scheduler side
  modport slave (
    input  d_valid, d_md, d_div, d_sign, d_hilo_rd, d_hilo_wr, ext_stall, da, db,
`ifdef PIPE_MD_ABORT_EN
    input  md_abort,
`endif
    output md_start, md_div, md_sign, md_a, md_b, md_busy, md_dz, hilo_we, md_stall
  );
endinterface

// File: rtl/pipe_md_sched.sv
// Multiply/divide scheduler beside the decode stage: latches operands on
// issue, counts RUN cycles, pulses the HI/LO write strobe in WB and stalls D
// while a HI/LO consumer or another mult/div would collide.
// Optional macro PIPE_MD_ABORT_EN adds md_abort, which squashes an operation
// in flight (and any same-cycle issue).
module pipe_md_sched #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic           clock,
  input  logic           reset,
  pipe_md_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            md_start_q;
  logic            md_div_q;
  logic            md_sign_q;
  logic            md_dz_q;
  logic            hilo_we_q;
  logic [31:0]     md_a_q;
  logic [31:0]     md_b_q;

  logic            abort;
  logic            busy;
  logic            stall;
  logic            issue;

`ifdef PIPE_MD_ABORT_EN
  assign abort = bus.md_abort;
`else
  assign abort = 1'b0;
`endif

  // HI/LO stays hazardous through WB: the result is visible only after that edge
  assign busy  = (state_q != IDLE);
  assign stall = busy & bus.d_valid & (bus.d_md | bus.d_hilo_rd | bus.d_hilo_wr);
  assign issue = bus.d_valid & bus.d_md & ~bus.ext_stall & ~stall & ~abort;

  // Sequencer: state, counter, latched operands and registered strobes
  // NOTE: every register here, datapath latches included, is cleared by the
  // async reset so an interrupted operation leaves nothing behind; all state
  // updates use non-blocking assignments so the case arms see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
      md_div_q   <= 1'b0;
      md_sign_q  <= 1'b0;
      md_dz_q    <= 1'b0;
      hilo_we_q  <= 1'b0;
      md_a_q     <= '0;
      md_b_q     <= '0;
    end else begin
      md_start_q <= 1'b0;
      hilo_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            md_start_q <= 1'b1;
            md_a_q     <= bus.da;
            md_b_q     <= bus.db;
            md_div_q   <= bus.d_div;
            md_sign_q  <= bus.d_sign;
            if (bus.d_div && (bus.db == '0)) begin
              // Divide-by-zero skips RUN and writes back immediately
              md_dz_q   <= 1'b1;
              hilo_we_q <= 1'b1;
              state_q   <= WB;
            end else begin
              md_dz_q <= 1'b0;
              cnt_q   <= bus.d_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            md_dz_q <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            hilo_we_q <= 1'b1;
            state_q   <= WB;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WB: begin
          if (abort) md_dz_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.md_start = md_start_q;
  assign bus.md_div   = md_div_q;
  assign bus.md_sign  = md_sign_q;
  assign bus.md_a     = md_a_q;
  assign bus.md_b     = md_b_q;
  assign bus.md_busy  = busy;
  assign bus.md_dz    = md_dz_q;
  // An abort landing in WB must still suppress that cycle's write
  assign bus.hilo_we  = hilo_we_q & ~abort;
  assign bus.md_stall = stall;

endmodule

// File: tb/tb_pipe_md_sched.sv
// Self-checking bench for pipe_md_sched: directed scenarios followed by a
// randomized phase, all checked against a cycle-number reference model.
module tb_pipe_md_sched;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic clock;
  logic reset;

  pipe_md_sched_if bus ();

  pipe_md_sched #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CW(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef PIPE_MD_ABORT_EN
  initial bus.md_abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: an issue at edge e makes cycle e the start cycle and
  // cycle e+N (or e for divide-by-zero) the write-back cycle; busy until then.
  int          cyc = 0;
  bit          m_active = 0;
  int          m_start_cyc = 0;
  int          m_wb_cyc = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_div = 1'b0;
  logic        m_sign = 1'b0;
  logic        m_dz = 1'b0;
  logic        last_stall = 1'b0;
  int          n_start = 0;
  int          n_we = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return m_active && (cyc <= m_wb_cyc);
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_a = '0; m_b = '0; m_div = 1'b0; m_sign = 1'b0; m_dz = 1'b0;
  endtask

  task automatic check_outputs();
    check("md_start", bus.md_start, m_active && cyc == m_start_cyc);
    check("hilo_we",  bus.hilo_we,  m_active && cyc == m_wb_cyc);
    check("md_busy",  bus.md_busy,  m_busy());
    check("md_a",     bus.md_a,     m_a);
    check("md_b",     bus.md_b,     m_b);
    check("md_div",   bus.md_div,   m_div);
    check("md_sign",  bus.md_sign,  m_sign);
    check("md_dz",    bus.md_dz,    m_dz);
  endtask

  task automatic set_idle();
    bus.d_valid = 1'b0; bus.d_md = 1'b0; bus.d_div = 1'b0; bus.d_sign = 1'b0;
    bus.d_hilo_rd = 1'b0; bus.d_hilo_wr = 1'b0; bus.ext_stall = 1'b0;
    bus.da = '0; bus.db = '0;
  endtask

  task automatic set_md(input logic div, input logic sign, input logic [31:0] a, input logic [31:0] b);
    bus.d_valid = 1'b1; bus.d_md = 1'b1; bus.d_div = div; bus.d_sign = sign;
    bus.d_hilo_rd = 1'b0; bus.d_hilo_wr = 1'b0; bus.ext_stall = 1'b0;
    bus.da = a; bus.db = b;
  endtask

  // One clock: check the combinational stall, advance, update model, check outputs
  task automatic tick();
    logic e_stall;
    logic e_issue;
    #1;
    e_stall = m_busy() && bus.d_valid && (bus.d_md || bus.d_hilo_rd || bus.d_hilo_wr);
    check("md_stall", bus.md_stall, e_stall);
    last_stall = bus.md_stall;
    e_issue = bus.d_valid && bus.d_md && !bus.ext_stall && !e_stall;
    @(posedge clock);
    cyc++;
    if (e_issue) begin
      m_active    = 1;
      m_start_cyc = cyc;
      m_dz        = bus.d_div && (bus.db == '0);
      m_wb_cyc    = m_dz ? cyc : cyc + (bus.d_div ? DIVN : MULN);
      m_a = bus.da; m_b = bus.db; m_div = bus.d_div; m_sign = bus.d_sign;
    end
    #1;
    if (bus.md_start === 1'b1) n_start++;
    if (bus.hilo_we === 1'b1) n_we++;
    check_outputs();
  endtask

  initial begin
    int cnt;
    int k;
    set_idle();
    reset = 1'b1;
    #1;
    check_outputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Multiply latency: one start pulse, one write strobe 4 edges after issue
    n_start = 0; n_we = 0;
    set_md(1'b0, 1'b1, 32'd7, 32'd6);
    tick();
    set_idle();
    k = 0;
    while (bus.hilo_we !== 1'b1 && k < 50) begin tick(); k++; end
    check("mul_wb_edges", k, MULN);
    check("mul_a_held", bus.md_a, 32'd7);
    check("mul_b_held", bus.md_b, 32'd6);
    tick();
    check("mul_idle_busy", bus.md_busy, 1'b0);
    check("mul_n_start", n_start, 1);
    check("mul_n_we", n_we, 1);

    // Divide by zero: WB right after issue, RUN skipped
    set_md(1'b1, 1'b0, 32'd9, 32'd0);
    tick();
    check("dz_flag", bus.md_dz, 1'b1);
    check("dz_we", bus.hilo_we, 1'b1);
    check("dz_start", bus.md_start, 1'b1);
    set_idle();
    tick();
    check("dz_done", bus.md_busy, 1'b0);

    // MFHI hazard behind a divide: 32 RUN cycles plus WB
    set_md(1'b1, 1'b1, 32'd100, 32'd7);
    tick();
    set_idle();
    bus.d_valid = 1'b1; bus.d_hilo_rd = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_stall === 1'b1) cnt++;
      else break;
    end
    check("mfhi_stall_cycles", cnt, DIVN + 1);
    set_idle();
    tick();

    // Back-to-back: MULT then DIV; DIV waits 5 cycles then issues
    set_md(1'b0, 1'b0, 32'hdead_beef, 32'h1234);
    tick();
    set_md(1'b1, 1'b0, 32'd1000, 32'd10);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_stall === 1'b1) cnt++;
      else break;
    end
    check("b2b_stall_cycles", cnt, MULN + 1);
    check("b2b_div", bus.md_div, 1'b1);
    check("b2b_start", bus.md_start, 1'b1);
    set_idle();
    k = 0;
    while (bus.hilo_we !== 1'b1 && k < 100) begin tick(); k++; end
    check("b2b_div_wb_edges", k, DIVN);
    tick();

    // ext_stall gating in IDLE, plus MFHI under a stall produces no md_stall
    set_md(1'b0, 1'b0, 32'd11, 32'd12);
    bus.ext_stall = 1'b1;
    bus.d_hilo_rd = 1'b1;
    repeat (3) begin
      tick();
      check("ext_no_start", bus.md_start, 1'b0);
      check("ext_no_stall", last_stall, 1'b0);
    end
    bus.ext_stall = 1'b0;
    bus.d_hilo_rd = 1'b0;
    tick();
    check("ext_issue", bus.md_start, 1'b1);
    set_idle();
    repeat (MULN + 2) tick();

    // Reset mid-RUN: no write-back, latches cleared
    n_we = 0;
    set_md(1'b0, 1'b0, 32'd3, 32'd5);
    tick();
    set_idle();
    tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_busy", bus.md_busy, 1'b0);
    check("rst_async_a", bus.md_a, 32'd0);
    @(posedge clock);
    cyc++;
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b0;
    repeat (MULN + 2) tick();
    check("rst_no_we", n_we, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.d_valid   = ($urandom_range(0, 9) < 8);
      bus.d_md      = ($urandom_range(0, 9) < 3);
      bus.d_div     = 1'($urandom_range(0, 1));
      bus.d_sign    = 1'($urandom_range(0, 1));
      bus.d_hilo_rd = ($urandom_range(0, 9) < 2);
      bus.d_hilo_wr = ($urandom_range(0, 9) < 1);
      bus.ext_stall = ($urandom_range(0, 9) < 2);
      bus.da        = $urandom;
      bus.db        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      tick();
    end
    set_idle();
    repeat (DIVN + 4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
